bias_bank_add: RTL and testbench

- Parametrised successor to the per-layer hard-wired bias constant banks.
- Holds a run-time-loadable bias bank of N_GROUPS groups × N_adder_tree lanes (18-bit signed each).
- Adds the selected group's biases to the adder-tree outputs, with saturation and optional ReLU.
- Sits between the adder tree and the activation/requantise stage; valid/ready on both sides. One instance serves all layers; biases are reloaded per layer.

---
 rtl/bias_pkg.sv | 35 +++
 rtl/bias_lane_add.sv | 40 ++++
 rtl/bias_bank_add.sv | 107 ++++++++++
 tb/tb_bias_bank_add.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_pkg.sv
// Shared definitions for the bias bank adder.
// Provides the default datapath width, a signed lane type at that width,
// the saturation limits and a reference saturating add for one lane.
package bias_pkg;

    localparam int DEF_DATA_W = 18;

    typedef logic signed [DEF_DATA_W-1:0] lane_t;

    localparam lane_t SAT_MAX = lane_t'({1'b0, {(DEF_DATA_W-1){1'b1}}});
    localparam lane_t SAT_MIN = lane_t'({1'b1, {(DEF_DATA_W-1){1'b0}}});

    typedef struct packed {
        logic  sat;
        lane_t value;
    } sat_res_t;

    // One-bit-wider add, then clamp. The two top bits of the wide sum
    // disagree exactly when the true result does not fit in a lane.
    function automatic sat_res_t sat_add(input lane_t a, input lane_t b);
        logic signed [DEF_DATA_W:0] s;
        sat_res_t                   r;
        s     = {a[DEF_DATA_W-1], a} + {b[DEF_DATA_W-1], b};
        r.sat = s[DEF_DATA_W] ^ s[DEF_DATA_W-1];
        if (!r.sat) begin
            r.value = s[DEF_DATA_W-1:0];
        end else if (s[DEF_DATA_W]) begin
            r.value = SAT_MIN;
        end else begin
            r.value = SAT_MAX;
        end
        return r;
    endfunction

endpackage

// File: rtl/bias_lane_add.sv
// Combinational saturating bias add plus optional ReLU for one lane.
// Ports:
//   acc     - adder-tree output for this lane (signed)
//   bias    - bias word selected for this lane (signed)
//   relu_en - clamp negative results to zero
//   result  - saturated (and optionally rectified) sum
//   sat     - the sum was clamped; ReLU does not clear it
module bias_lane_add
    import bias_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic signed [DATA_W-1:0] acc,
    input  logic signed [DATA_W-1:0] bias,
    input  logic                     relu_en,
    output logic signed [DATA_W-1:0] result,
    output logic                     sat
);

    localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W:0]   sum;
    logic signed [DATA_W-1:0] clamped;

    always_comb begin
        sum = {acc[DATA_W-1], acc} + {bias[DATA_W-1], bias};
        // Overflow iff the extension bit differs from the lane sign bit.
        sat = sum[DATA_W] ^ sum[DATA_W-1];
        if (!sat) begin
            clamped = sum[DATA_W-1:0];
        end else if (sum[DATA_W]) begin
            clamped = MIN_V;
        end else begin
            clamped = MAX_V;
        end
        result = (relu_en && clamped[DATA_W-1]) ? '0 : clamped;
    end

endmodule

// File: rtl/bias_bank_add.sv
// Run-time loadable bias bank added to adder-tree outputs.
// Stores N_GROUPS x N_adder_tree signed bias words; each accepted beat adds
// the selected group's biases lane by lane, saturating, with optional ReLU.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   relu_en                          - clamp negatives to 0, sampled at accept
//   bias_wr_en/grp/lane/data         - single bias word write port
//   in_valid/in_ready/in_grp/in_data - input beat, lane k at [DATA_W*k +: DATA_W]
//   out_valid/out_ready/out_data     - registered result, same packing
//   out_sat                          - per-lane saturation flags of the held beat
//
// Handshake: a beat transfers on any edge where valid && ready are both high.
// in_ready = !out_valid || out_ready, so the single output register can be
// refilled in the same cycle it is drained; valid never waits on ready, and
// the output holds data and flags stable while out_valid && !out_ready.
module bias_bank_add
    import bias_pkg::*;
#(
    parameter int N_adder_tree = 16,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int N_GROUPS     = 4,
    parameter int GRP_W        = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
    parameter int LANE_W       = (N_adder_tree > 1) ? $clog2(N_adder_tree) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           relu_en,
    input  logic                           bias_wr_en,
    input  logic [GRP_W-1:0]               bias_wr_grp,
    input  logic [LANE_W-1:0]              bias_wr_lane,
    input  logic signed [DATA_W-1:0]       bias_wr_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [GRP_W-1:0]               in_grp,
    input  logic [N_adder_tree*DATA_W-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_adder_tree*DATA_W-1:0] out_data,
    output logic [N_adder_tree-1:0]        out_sat
);

    // Limits one bit wider than the index so non-power-of-two sizes compare cleanly.
    localparam logic [GRP_W:0]  GRP_LIMIT  = (GRP_W+1)'(N_GROUPS);
    localparam logic [LANE_W:0] LANE_LIMIT = (LANE_W+1)'(N_adder_tree);

    logic signed [DATA_W-1:0] bank [N_GROUPS][N_adder_tree];

    logic                           wr_ok;
    logic                           grp_ok;
    logic                           accept;
    logic [N_adder_tree*DATA_W-1:0] res_data;
    logic [N_adder_tree-1:0]        res_sat;

    assign wr_ok    = bias_wr_en
                   && ({1'b0, bias_wr_grp}  < GRP_LIMIT)
                   && ({1'b0, bias_wr_lane} < LANE_LIMIT);
    assign grp_ok   = ({1'b0, in_grp} < GRP_LIMIT);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Bias register file. The read path below sees the pre-edge contents,
    // so a write coinciding with an accept affects only later beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int g = 0; g < N_GROUPS; g++) begin
                for (int l = 0; l < N_adder_tree; l++) begin
                    bank[g][l] <= '0;
                end
            end
        end else if (wr_ok) begin
            bank[bias_wr_grp][bias_wr_lane] <= bias_wr_data;
        end
    end

    for (genvar k = 0; k < N_adder_tree; k++) begin : g_lane
        logic signed [DATA_W-1:0] bias_k;

        // An out-of-range group contributes no bias.
        assign bias_k = grp_ok ? bank[in_grp][k] : '0;

        bias_lane_add #(
            .DATA_W (DATA_W)
        ) u_lane (
            .acc     (in_data[DATA_W*k +: DATA_W]),
            .bias    (bias_k),
            .relu_en (relu_en),
            .result  (res_data[DATA_W*k +: DATA_W]),
            .sat     (res_sat[k])
        );
    end

    // Single output register; data is left untouched when it drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= res_data;
            out_sat   <= res_sat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bias_bank_add.sv
// Self-checking bench for bias_bank_add: directed scenarios plus randomized
// streaming against a behavioural model (integer add, clamp, ReLU, queue).
module tb_bias_bank_add;

    localparam int N    = 16;
    localparam int DW   = 18;
    localparam int NG   = 4;
    localparam int IW   = N * DW;
    localparam int OW   = IW + N;
    localparam int N2   = 3;
    localparam int NG2  = 3;
    localparam int IW2  = N2 * DW;
    localparam int SMAX = (1 << (DW - 1)) - 1;
    localparam int SMIN = -(1 << (DW - 1));

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main DUT (default parameters)
    logic          relu_en, bias_wr_en, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]    bias_wr_grp, in_grp;
    logic [3:0]    bias_wr_lane;
    logic [DW-1:0] bias_wr_data;
    logic [IW-1:0] in_data, out_data;
    logic [N-1:0]  out_sat;

    // second DUT with non-power-of-two sizes to reach out-of-range indices
    logic          relu_en2, bias_wr_en2, in_valid2, in_ready2, out_valid2, out_ready2;
    logic [1:0]    bias_wr_grp2, in_grp2, bias_wr_lane2;
    logic [DW-1:0] bias_wr_data2;
    logic [IW2-1:0] in_data2, out_data2;
    logic [N2-1:0] out_sat2;

    bias_bank_add dut (
        .clk(clk), .rst(rst), .relu_en(relu_en),
        .bias_wr_en(bias_wr_en), .bias_wr_grp(bias_wr_grp),
        .bias_wr_lane(bias_wr_lane), .bias_wr_data(bias_wr_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_grp(in_grp), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    bias_bank_add #(.N_adder_tree(N2), .N_GROUPS(NG2)) dut2 (
        .clk(clk), .rst(rst), .relu_en(relu_en2),
        .bias_wr_en(bias_wr_en2), .bias_wr_grp(bias_wr_grp2),
        .bias_wr_lane(bias_wr_lane2), .bias_wr_data(bias_wr_data2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_grp(in_grp2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_sat(out_sat2)
    );

    // ---------------- scoreboard / model state ----------------
    int            errors = 0;
    int            checks = 0;
    int            bank_m [NG][N];
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] last_val;
    logic          ov_m;

    function automatic int lane_of(input logic [IW-1:0] d, input int k);
        return int'($signed(d[k*DW +: DW]));
    endfunction

    // Expected {sat, data} for one beat from plain integer arithmetic.
    function automatic logic [OW-1:0] model_beat(input logic [IW-1:0] d, input int g,
                                                 input logic relu);
        logic [OW-1:0] r;
        int            s;
        r = '0;
        for (int k = 0; k < N; k++) begin
            s = lane_of(d, k) + ((g < NG) ? bank_m[g][k] : 0);
            if (s > SMAX) begin
                s = SMAX;
                r[IW+k] = 1'b1;
            end else if (s < SMIN) begin
                s = SMIN;
                r[IW+k] = 1'b1;
            end
            if (relu && s < 0) s = 0;
            r[k*DW +: DW] = s[DW-1:0];
        end
        return r;
    endfunction

    function automatic int rand_lane();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 2*SMAX+1)) + SMIN;
            1:       return int'($urandom_range(0, 2000)) - 1000;
            2:       return SMAX - int'($urandom_range(0, 3000));
            default: return SMIN + int'($urandom_range(0, 3000));
        endcase
    endfunction

    function automatic logic [IW-1:0] rand_data();
        logic [IW-1:0] d;
        for (int k = 0; k < N; k++) d[k*DW +: DW] = DW'(rand_lane());
        return d;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        relu_en = 0; bias_wr_en = 0; bias_wr_grp = 0; bias_wr_lane = 0; bias_wr_data = 0;
        in_valid = 0; in_grp = 0; in_data = '0; out_ready = 1;
        relu_en2 = 0; bias_wr_en2 = 0; bias_wr_grp2 = 0; bias_wr_lane2 = 0; bias_wr_data2 = 0;
        in_valid2 = 0; in_grp2 = 0; in_data2 = '0; out_ready2 = 1;
    endtask

    task automatic clear_model();
        for (int g = 0; g < NG; g++)
            for (int l = 0; l < N; l++) bank_m[g][l] = 0;
        exp_q.delete();
        ov_m     = 1'b0;
        last_val = '0;
    endtask

    task automatic write_bias(input int g, input int l, input int v);
        bias_wr_en = 1; bias_wr_grp = 2'(g); bias_wr_lane = 4'(l); bias_wr_data = DW'(v);
        step();
        bias_wr_en = 0;
        bank_m[g][l] = v;
    endtask

    task automatic send_beat(input int g, input logic [IW-1:0] d, input logic relu);
        in_valid = 1; in_grp = 2'(g); in_data = d; relu_en = relu; out_ready = 1;
        step();
        in_valid = 0;
    endtask

    task automatic write2(input int g, input int l, input int v);
        bias_wr_en2 = 1; bias_wr_grp2 = 2'(g); bias_wr_lane2 = 2'(l); bias_wr_data2 = DW'(v);
        step();
        bias_wr_en2 = 0;
    endtask

    task automatic send2(input int g, input logic [IW2-1:0] d);
        in_valid2 = 1; in_grp2 = 2'(g); in_data2 = d; out_ready2 = 1;
        step();
        in_valid2 = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        in_valid = 1; bias_wr_en = 1; in_data = rand_data(); out_ready = 0;
        rst = 1;
        step();
        rst = 0;
        drive_idle();
        out_ready = 0;
        clear_model();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (out_sat !== '0) begin errors++; $display("FAIL reset_out_sat: got %h want 0", out_sat); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL reset_out_valid2: got %b want 0", out_valid2); end
        out_ready = 1;
    endtask

    task automatic test_basic();
        logic [IW-1:0] d;
        logic [OW-1:0] e;
        write_bias(0, 0, 8836);
        d = '0;
        d[DW-1:0] = DW'(100);
        e = model_beat(d, 0, 1'b0);
        send_beat(0, d, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        checks++; if (lane_of(out_data, 0) != 8936) begin errors++; $display("FAIL basic_lane0: got %0d want 8936", lane_of(out_data, 0)); end
        checks++; if ({out_sat, out_data} !== e) begin errors++; $display("FAIL basic_beat: got %h want %h", {out_sat, out_data}, e); end
        checks++; if (out_sat !== '0) begin errors++; $display("FAIL basic_sat: got %h want 0", out_sat); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", out_valid); end
        checks++; if ({out_sat, out_data} !== e) begin errors++; $display("FAIL basic_hold: got %h want %h", {out_sat, out_data}, e); end
        // a fully random beat on a group with a nonzero bias
        d = rand_data();
        e = model_beat(d, 0, 1'b0);
        send_beat(0, d, 1'b0);
        checks++; if ({out_sat, out_data} !== e) begin errors++; $display("FAIL basic_random: got %h want %h", {out_sat, out_data}, e); end
        last_val = e;
        step();
    endtask

    task automatic test_saturation();
        logic [IW-1:0] d;
        logic [OW-1:0] e;
        write_bias(0, 3, -1948);
        write_bias(0, 5, 1000);
        d = '0;
        d[3*DW +: DW] = DW'(-131000);
        d[5*DW +: DW] = DW'(131000);
        d[7*DW +: DW] = DW'(-5);
        e = model_beat(d, 0, 1'b0);
        send_beat(0, d, 1'b0);
        checks++; if (lane_of(out_data, 3) != -131072) begin errors++; $display("FAIL sat_min_value: got %0d want -131072", lane_of(out_data, 3)); end
        checks++; if (out_sat[3] !== 1'b1) begin errors++; $display("FAIL sat_min_flag: got %b want 1", out_sat[3]); end
        checks++; if (lane_of(out_data, 5) != 131071) begin errors++; $display("FAIL sat_max_value: got %0d want 131071", lane_of(out_data, 5)); end
        checks++; if (out_sat[5] !== 1'b1) begin errors++; $display("FAIL sat_max_flag: got %b want 1", out_sat[5]); end
        checks++; if ({out_sat, out_data} !== e) begin errors++; $display("FAIL sat_beat: got %h want %h", {out_sat, out_data}, e); end
        last_val = e;
        step();
    endtask

    task automatic test_relu();
        logic [IW-1:0] d;
        logic [OW-1:0] e;
        write_bias(2, 1, -500);
        d = rand_data();
        d[DW +: DW] = DW'(200);
        e = model_beat(d, 2, 1'b1);
        send_beat(2, d, 1'b1);
        checks++; if (lane_of(out_data, 1) != 0) begin errors++; $display("FAIL relu_on_lane1: got %0d want 0", lane_of(out_data, 1)); end
        checks++; if (out_sat[1] !== 1'b0) begin errors++; $display("FAIL relu_on_sat1: got %b want 0", out_sat[1]); end
        checks++; if ({out_sat, out_data} !== e) begin errors++; $display("FAIL relu_on_beat: got %h want %h", {out_sat, out_data}, e); end
        e = model_beat(d, 2, 1'b0);
        send_beat(2, d, 1'b0);
        checks++; if (lane_of(out_data, 1) != -300) begin errors++; $display("FAIL relu_off_lane1: got %0d want -300", lane_of(out_data, 1)); end
        checks++; if ({out_sat, out_data} !== e) begin errors++; $display("FAIL relu_off_beat: got %h want %h", {out_sat, out_data}, e); end
        last_val = e;
        step();
    endtask

    task automatic test_hazard();
        logic [IW-1:0] d;
        logic [OW-1:0] e;
        write_bias(1, 2, 50);
        d = rand_data();
        d[2*DW +: DW] = '0;
        e = model_beat(d, 1, 1'b0);
        bias_wr_en = 1; bias_wr_grp = 2'd1; bias_wr_lane = 4'd2; bias_wr_data = DW'(70);
        in_valid = 1; in_grp = 2'd1; in_data = d; relu_en = 0; out_ready = 1;
        step();
        bias_wr_en = 0; in_valid = 0;
        bank_m[1][2] = 70;
        checks++; if (lane_of(out_data, 2) != 50) begin errors++; $display("FAIL hazard_old_bias: got %0d want 50", lane_of(out_data, 2)); end
        checks++; if ({out_sat, out_data} !== e) begin errors++; $display("FAIL hazard_beat: got %h want %h", {out_sat, out_data}, e); end
        d = rand_data();
        d[2*DW +: DW] = '0;
        e = model_beat(d, 1, 1'b0);
        send_beat(1, d, 1'b0);
        checks++; if (lane_of(out_data, 2) != 70) begin errors++; $display("FAIL hazard_new_bias: got %0d want 70", lane_of(out_data, 2)); end
        checks++; if ({out_sat, out_data} !== e) begin errors++; $display("FAIL hazard_next_beat: got %h want %h", {out_sat, out_data}, e); end
        last_val = e;
        step();
    endtask

    // rnd=0: in_valid held, 5-cycle stall then full throughput.
    // rnd=1: random valid/ready, random bias writes racing the datapath.
    task automatic test_stream(input int ncycles, input bit rnd);
        logic [IW-1:0] cur_d;
        int            cur_g, wg, wl, wv;
        logic          cur_relu, acc_m;
        logic [OW-1:0] want;
        cur_d = rand_data(); cur_g = $urandom_range(0, NG-1); cur_relu = 1'($urandom_range(0, 1));
        wg = 0; wl = 0; wv = 0;
        for (int c = 0; c < ncycles; c++) begin
            if (rnd) begin
                in_valid   = (c < ncycles-4) && ($urandom_range(0, 3) != 0);
                out_ready  = ($urandom_range(0, 3) != 0);
                bias_wr_en = ($urandom_range(0, 2) == 0);
                wg = $urandom_range(0, NG-1); wl = $urandom_range(0, N-1); wv = rand_lane();
                bias_wr_grp = 2'(wg); bias_wr_lane = 4'(wl); bias_wr_data = DW'(wv);
            end else begin
                in_valid   = (c < ncycles-4);
                out_ready  = !(c >= 2 && c <= 6);
                bias_wr_en = 0;
            end
            if (c >= ncycles-4) out_ready = 1;
            in_grp = 2'(cur_g); in_data = cur_d; relu_en = cur_relu;
            #1;
            want = last_val;
            if (ov_m) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL stream_queue: got empty want entry at cycle %0d", c);
                end else begin
                    want = exp_q[0];
                end
            end
            checks++; if (in_ready !== (!ov_m || out_ready)) begin errors++; $display("FAIL stream_in_ready c%0d: got %b want %b", c, in_ready, (!ov_m || out_ready)); end
            checks++; if (out_valid !== ov_m) begin errors++; $display("FAIL stream_out_valid c%0d: got %b want %b", c, out_valid, ov_m); end
            checks++; if ({out_sat, out_data} !== want) begin errors++; $display("FAIL stream_out c%0d: got %h want %h", c, {out_sat, out_data}, want); end
            acc_m = in_valid && (!ov_m || out_ready);
            if (ov_m && out_ready && exp_q.size() > 0) last_val = exp_q.pop_front();
            if (acc_m) exp_q.push_back(model_beat(cur_d, cur_g, cur_relu));
            ov_m = acc_m ? 1'b1 : (out_ready ? 1'b0 : ov_m);
            if (bias_wr_en) bank_m[wg][wl] = wv;
            if (acc_m || !in_valid) begin
                cur_d = rand_data(); cur_g = $urandom_range(0, NG-1); cur_relu = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
        end
        in_valid = 0; bias_wr_en = 0; out_ready = 1;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_drained: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_mid_reset();
        logic [IW-1:0] d;
        write_bias(1, 0, 1234);
        in_valid = 1; in_grp = 2'd1; in_data = rand_data(); relu_en = 0; out_ready = 0;
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_held: got %b want 1", out_valid); end
        rst = 1;
        bias_wr_en = 1; bias_wr_grp = 2'd1; bias_wr_lane = 4'd0; bias_wr_data = DW'(5555);
        in_valid = 1;
        step();
        rst = 0;
        drive_idle();
        clear_model();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL midrst_data: got %h want 0", out_data); end
        checks++; if (out_sat !== '0) begin errors++; $display("FAIL midrst_sat: got %h want 0", out_sat); end
        for (int g = 0; g < NG; g++) begin
            d = rand_data();
            send_beat(g, d, 1'b0);
            checks++; if (out_data !== d) begin errors++; $display("FAIL midrst_pass g%0d: got %h want %h", g, out_data, d); end
            checks++; if (out_sat !== '0) begin errors++; $display("FAIL midrst_pass_sat g%0d: got %h want 0", g, out_sat); end
            last_val = {N'(0), d};
        end
        step();
    endtask

    task automatic test_out_of_range();
        logic [IW2-1:0] d;
        int             v [N2];
        write2(0, 0, 111);
        write2(2, 2, -7);
        write2(3, 0, 999);
        write2(0, 3, 999);
        write2(1, 3, 999);
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < N2; k++) begin
                v[k] = int'($urandom_range(0, 100000)) - 50000;
                d[k*DW +: DW] = DW'(v[k]);
            end
            if (g == 0) v[0] = v[0] + 111;
            if (g == 2) v[2] = v[2] - 7;
            send2(g, d);
            for (int k = 0; k < N2; k++) begin
                checks++;
                if (int'($signed(out_data2[k*DW +: DW])) != v[k]) begin
                    errors++;
                    $display("FAIL oor g%0d lane%0d: got %0d want %0d", g, k, int'($signed(out_data2[k*DW +: DW])), v[k]);
                end
            end
            checks++; if (out_sat2 !== '0) begin errors++; $display("FAIL oor_sat g%0d: got %b want 0", g, out_sat2); end
        end
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        drive_idle();
        rst = 1;
        clear_model();
        test_reset();
        test_basic();
        test_saturation();
        test_relu();
        test_hazard();
        ov_m = 1'b0;
        test_stream(30, 1'b0);
        test_stream(400, 1'b1);
        test_mid_reset();
        test_out_of_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
